ipf_result_drain: RTL

Receive-side companion to the IPF convolution core. It accepts each wide result frame that IPF presents with the single-cycle `res_valid` strobe, holds it in a two-entry ping-pong buffer, and streams it out as fixed-width beats over a valid/ready interface toward the output DMA or SRAM writer. Frames that arrive while both buffers are occupied are dropped and flagged rather than stalling IPF, because IPF has no backpressure input.

---
 rtl/ipf_pkg.sv | 14 +
 rtl/ipf_drain_buf.sv | 27 ++
 rtl/ipf_result_drain.sv | 89 ++++++++
 3 files changed

// File: rtl/ipf_pkg.sv
// Shared IPF constants: result-bus geometry and the drain FSM state type.
package ipf_pkg;

  localparam int unsigned RES_W = 9216;
  localparam int unsigned OUT_W = 64;
  localparam int unsigned BEATS = RES_W / OUT_W;
  localparam int unsigned IDX_W = 8;

  typedef enum logic {
    DRN_IDLE = 1'b0,
    DRN_RUN  = 1'b1
  } drn_state_e;

endpackage

// File: rtl/ipf_drain_buf.sv
// One result-frame holding register with a beat-select read mux.
module ipf_drain_buf #(
  parameter int unsigned RES_W = 9216,
  parameter int unsigned OUT_W = 64,
  parameter int unsigned BEATS = RES_W / OUT_W,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [RES_W-1:0] din,
  input  logic [IDX_W-1:0] sel,
  output logic [OUT_W-1:0] beat_c
);

  logic [BEATS-1:0][OUT_W-1:0] data_q;

  // Payload register carries no reset; the full flags in the top qualify it.
  always_ff @(posedge clk) begin
    if (load) data_q <= din;
  end

  always_comb begin
    beat_c = '0;
    if (sel <= IDX_W'(BEATS - 1)) beat_c = data_q[sel];
  end

endmodule

// File: rtl/ipf_result_drain.sv
// Ping-pong capture of IPF result frames, drained as OUT_W beats over valid/ready.
module ipf_result_drain #(
  parameter int unsigned RES_W = ipf_pkg::RES_W,
  parameter int unsigned OUT_W = ipf_pkg::OUT_W,
  parameter int unsigned BEATS = RES_W / OUT_W,
  parameter int unsigned IDX_W = ipf_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  input  logic [RES_W-1:0] result,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last,
  output logic [7:0]       frame_cnt,
  output logic             ovf,
  output logic             busy
);

  import ipf_pkg::*;

  drn_state_e       state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic             wp_q, rp_q;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic             hs, last_hs, cap, drop;
  logic [OUT_W-1:0] buf_beat [2];

  // Next-state: the other buffer can only be written, never the one draining.
  always_comb begin
    hs      = o_valid & o_ready;
    last_hs = hs & o_last;
    cap     = res_valid & ~full_q[wp_q];
    drop    = res_valid & full_q[wp_q];
    full_d  = full_q;
    beat_d  = beat_q;
    if (last_hs) full_d[rp_q] = 1'b0;
    if (cap)     full_d[wp_q] = 1'b1;
    if (last_hs)  beat_d = '0;
    else if (hs)  beat_d = beat_q + IDX_W'(1);
    state_d = (|full_d) ? DRN_RUN : DRN_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DRN_IDLE;
      full_q    <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      beat_q    <= '0;
      o_last    <= 1'b0;
      frame_cnt <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wp_q      <= wp_q ^ cap;
      rp_q      <= rp_q ^ last_hs;
      beat_q    <= beat_d;
      o_last    <= (state_d == DRN_RUN) && (beat_d == IDX_W'(BEATS - 1));
      frame_cnt <= frame_cnt + 8'(last_hs);
      ovf       <= ovf | drop;
      busy      <= |full_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_buf
    ipf_drain_buf #(
      .RES_W(RES_W),
      .OUT_W(OUT_W),
      .BEATS(BEATS),
      .IDX_W(IDX_W)
    ) u_buf (
      .clk   (clk),
      .load  (cap && (wp_q == 1'(i))),
      .din   (result),
      .sel   (beat_q),
      .beat_c(buf_beat[i])
    );
  end

  assign o_valid = (state_q == DRN_RUN);
  assign o_idx   = beat_q;
  assign o_data  = o_valid ? buf_beat[rp_q] : '0;

endmodule
